fsm_arbiter_rr: RTL and testbench



---
 rtl/fsm_arbiter_rr.sv | 96 +++++++++
 tb/tb_fsm_arbiter_rr.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fsm_arbiter_rr.sv
// N-requester registered grant arbiter with fixed-priority or round-robin
// selection and an optional maximum-hold forced release.
module fsm_arbiter_rr #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [0:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [7:0]         hold_cnt;
  logic [NUM_REQ-1:0] mask;

  logic [NUM_REQ-1:0] eff, rot, rot_oh, win_oh;
  logic [ID_W-1:0]    base, off, win, next_ptr;
  logic               any_eff, owner_req, others;
  int                 win_sum;

  // Rotate the eligible requests so the search origin sits at bit 0, pick the
  // lowest set bit, then rotate the one-hot winner back into place.
  always_comb begin
    eff     = req & ~mask;
    any_eff = |eff;
    base    = rr_mode ? rr_ptr : '0;
    rot     = NUM_REQ'({eff, eff} >> base);
    rot_oh  = '0;
    off     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (rot[k] && (rot_oh == '0)) begin
        rot_oh[k] = 1'b1;
        off       = ID_W'(k);
      end
    end
    win_oh  = NUM_REQ'(({rot_oh, rot_oh} << base) >> NUM_REQ);
    win_sum = int'(base) + int'(off);
    if (win_sum >= NUM_REQ) win_sum = win_sum - NUM_REQ;
    win      = ID_W'(win_sum);
    next_ptr = (win_sum + 1 >= NUM_REQ) ? '0 : ID_W'(win_sum + 1);
    owner_req = |(req & gnt);
    others    = |(req & ~gnt);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      mask      <= '0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE) begin
        mask <= '0;
        if (any_eff) begin
          state     <= GRANT;
          gnt       <= win_oh;
          gnt_valid <= 1'b1;
          gnt_id    <= win;
          rr_ptr    <= next_ptr;
          hold_cnt  <= 8'd1;
        end
      end else begin
        if (!owner_req) begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_MAX) && others) begin
          state     <= IDLE;
          gnt       <= '0;
          gnt_valid <= 1'b0;
          timeout   <= 1'b1;
          mask      <= gnt;
        end else if (hold_cnt < HOLD_MAX) begin
          hold_cnt <= hold_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_arbiter_rr.sv
// Randomised and directed bench for fsm_arbiter_rr against an integer-level
// model of owner, hold time, banned requester and round-robin pointer.
module tb_fsm_arbiter_rr;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic       rr_mode;
  logic [1:0] req_c;

  logic [3:0] gnt_a, gnt_b;
  logic       gv_a, gv_b, to_a, to_b;
  logic [1:0] id_a, id_b;
  logic [1:0] gnt_c;
  logic       gv_c, to_c;
  logic [0:0] id_c;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clock = ~clock;

  fsm_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(4)) dut_a (
    .clock(clock), .reset_n(reset_n), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_a), .gnt_valid(gv_a), .gnt_id(id_a), .timeout(to_a));

  fsm_arbiter_rr #(.NUM_REQ(4), .MAX_HOLD(0)) dut_b (
    .clock(clock), .reset_n(reset_n), .req(req), .rr_mode(rr_mode),
    .gnt(gnt_b), .gnt_valid(gv_b), .gnt_id(id_b), .timeout(to_b));

  fsm_arbiter_rr #(.NUM_REQ(2), .MAX_HOLD(3), .ID_W(1)) dut_c (
    .clock(clock), .reset_n(reset_n), .req(req_c), .rr_mode(1'b1),
    .gnt(gnt_c), .gnt_valid(gv_c), .gnt_id(id_c), .timeout(to_c));

  typedef struct {
    int owner;   // -1 when idle
    int held;
    int banned;  // -1 when nobody is excluded
    int ptr;
    int id;
    bit to;
  } mdl_t;

  mdl_t ma, mb, mc;

  function automatic mdl_t mstep(mdl_t m, int rq, bit rr, int n, int maxh, bit rst);
    mdl_t r;
    int   cand;
    int   k;
    bit   found;
    r = m;
    if (rst) begin
      r.owner = -1; r.held = 0; r.banned = -1; r.ptr = 0; r.id = 0; r.to = 0;
      return r;
    end
    r.to = 0;
    if (m.owner < 0) begin
      cand = rq;
      if (m.banned >= 0) cand = cand & ~(1 << m.banned);
      r.banned = -1;
      found = 0;
      for (int i = 0; i < n; i++) begin
        k = rr ? (m.ptr + i) % n : i;
        if (!found && ((cand >> k) & 1) == 1) begin
          found   = 1;
          r.owner = k;
          r.id    = k;
          r.held  = 1;
          r.ptr   = (k + 1) % n;
        end
      end
    end else if (((rq >> m.owner) & 1) == 0) begin
      r.owner = -1;
    end else if (maxh != 0 && m.held >= maxh && (rq & ~(1 << m.owner)) != 0) begin
      r.banned = m.owner;
      r.owner  = -1;
      r.to     = 1;
    end else begin
      r.held = m.held + 1;
    end
    return r;
  endfunction

  function automatic int exp_gnt(mdl_t m);
    return (m.owner < 0) ? 0 : (1 << m.owner);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_model(input string nm, input mdl_t m, input int g, input int v,
                             input int id, input int to);
    check({nm, ".gnt"},       g,  exp_gnt(m));
    check({nm, ".gnt_valid"}, v,  (m.owner >= 0) ? 1 : 0);
    check({nm, ".gnt_id"},    id, m.id);
    check({nm, ".timeout"},   to, int'(m.to));
  endtask

  // One clock: models advance on the same sampled inputs, outputs checked mid-cycle.
  task automatic tick();
    @(posedge clock);
    ma = mstep(ma, int'(req),   rr_mode, 4, 4, !reset_n);
    mb = mstep(mb, int'(req),   rr_mode, 4, 0, !reset_n);
    mc = mstep(mc, int'(req_c), 1'b1,    2, 3, !reset_n);
    @(negedge clock);
    check_model("a", ma, int'(gnt_a), int'(gv_a), int'(id_a), int'(to_a));
    check_model("b", mb, int'(gnt_b), int'(gv_b), int'(id_b), int'(to_b));
    check_model("c", mc, int'(gnt_c), int'(gv_c), int'(id_c), int'(to_c));
    check("c.onehot", int'($countones(gnt_c) <= 1), 1);
    if ($urandom_range(0, 2) == 0) req_c = req_c ^ 2'($urandom_range(1, 3));
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) tick();
    reset_n = 1'b1;
  endtask

  int      owners[$];
  int      n_to;
  bit      prev_v;
  mdl_t    zero_m;

  initial begin
    zero_m = '{owner: -1, held: 0, banned: -1, ptr: 0, id: 0, to: 0};
    ma = zero_m; mb = zero_m; mc = zero_m;
    reset_n = 1'b0; req = 4'b1111; rr_mode = 1'b1; req_c = 2'b00;
    @(negedge clock);

    // Reset held with all requests active, then first grant.
    do_reset(3);
    tick();
    check("reset.first_gnt", int'(gnt_a), 4'b0001);

    // Fixed priority, no timeout (dut_b).
    rr_mode = 1'b0; do_reset(1);
    req = 4'b1010;
    tick();
    check("fixed.gnt", int'(gnt_b), 4'b0010);
    check("fixed.id", int'(id_b), 1);
    tick();
    req = 4'b1000;
    tick();
    check("fixed.gap", int'(gnt_b), 0);
    tick();
    check("fixed.next", int'(gnt_b), 4'b1000);
    check("fixed.next_id", int'(id_b), 3);

    // Round-robin rotation with forced release (dut_a).
    rr_mode = 1'b1; req = 4'b0000; do_reset(1);
    req = 4'b1111;
    owners.delete(); n_to = 0; prev_v = 1'b0;
    repeat (24) begin
      tick();
      if (gv_a && !prev_v) owners.push_back(int'(id_a));
      if (to_a) n_to++;
      prev_v = gv_a;
    end
    check("rr.grant_count", owners.size(), 5);
    foreach (owners[i]) check("rr.order", owners[i], i % 4);
    check("rr.timeouts", n_to, 4);

    // Lone owner keeps the grant with no timeout.
    req = 4'b0000; do_reset(1);
    req = 4'b0001; n_to = 0;
    repeat (20) begin
      tick();
      if (to_a) n_to++;
    end
    check("lone.gnt", int'(gnt_a), 4'b0001);
    check("lone.timeouts", n_to, 0);

    // Fixed mode: mask after timeout lets requester 1 in.
    rr_mode = 1'b0; req = 4'b0000; do_reset(1);
    req = 4'b0011;
    repeat (5) tick();
    check("mask.to1", int'(to_a), 1);
    tick();
    check("mask.second", int'(gnt_a), 4'b0010);
    repeat (4) tick();
    check("mask.to2", int'(to_a), 1);
    tick();
    check("mask.back", int'(gnt_a), 4'b0001);

    // Owner drops request on the timeout edge: voluntary release wins.
    req = 4'b0000; do_reset(1);
    req = 4'b0011;
    repeat (4) tick();
    req = 4'b0010;
    tick();
    check("simul.gnt", int'(gnt_a), 0);
    check("simul.timeout", int'(to_a), 0);
    tick();
    check("simul.next", int'(gnt_a), 4'b0010);

    // Random traffic, mode changes and occasional mid-grant reset.
    req = 4'b0000; do_reset(1);
    repeat (400) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
      reset_n = ($urandom_range(0, 63) != 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
